merge_n: RTL and testbench



---
 rtl/merge_n.sv | 163 ++++++++++++++++
 tb/tb_merge_n.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/merge_n.sv
// N-way merge onto one registered output: the source is picked either by a
// queued select token (MODE=0) or by a round-robin arbiter (MODE=1).
module merge_n #(
  parameter int WIDTH     = 33,
  parameter int N         = 4,
  parameter int SEL_DEPTH = 4,
  parameter int MODE      = 0,
  localparam int SW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic               sel_valid,
  output logic               sel_ready,
  input  logic [SW-1:0]      sel_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SW-1:0]      out_src,
  output logic               sel_err
);

  localparam int AW = (SEL_DEPTH > 1) ? $clog2(SEL_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(SEL_DEPTH);

  // Handshake: a channel transfers on a rising clk when valid && ready; valid
  // never waits on ready, while every ready here is derived from valid and state.

  logic [SW-1:0]    fifo_mem [SEL_DEPTH];
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;
  logic [AW:0]      fifo_cnt;
  logic             fifo_empty;
  logic             fifo_full;
  logic [SW-1:0]    sel_head;
  logic             push;
  logic             pop;
  logic             drop;

  logic [SW-1:0]    ptr;
  logic             arb_hit;
  logic [SW-1:0]    arb_idx;

  logic             load_ok;
  logic             head_in_range;
  logic             head_valid;
  logic             grant_any;
  logic [SW-1:0]    grant_idx;
  logic [WIDTH-1:0] grant_data;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == DEPTH_W);
  assign sel_head   = fifo_mem[rd_idx];
  assign sel_ready  = (MODE == 0) && !fifo_full;
  assign push       = sel_valid && sel_ready;
  assign load_ok    = !out_valid || out_ready;

  // Range check and head-valid lookup in one pass so a head >= N never indexes in_valid.
  always_comb begin
    head_in_range = 1'b0;
    head_valid    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel_head == SW'(i)) begin
        head_in_range = 1'b1;
        head_valid    = in_valid[i];
      end
    end
  end

  // Round-robin search starting at ptr, wrapping modulo N.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!arb_hit && in_valid[j]) begin
        arb_hit = 1'b1;
        arb_idx = SW'(j);
      end
    end
  end

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    pop       = 1'b0;
    drop      = 1'b0;
    if (MODE == 0) begin
      if (!fifo_empty) begin
        if (!head_in_range) begin
          pop  = 1'b1;
          drop = 1'b1;
        end else if (head_valid && load_ok) begin
          grant_any = 1'b1;
          grant_idx = sel_head;
          pop       = 1'b1;
        end
      end
    end else if (arb_hit && load_ok) begin
      grant_any = 1'b1;
      grant_idx = arb_idx;
    end
  end

  always_comb begin
    in_ready   = '0;
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == SW'(i)) begin
        in_ready[i] = grant_any;
        grant_data  = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_idx] <= sel_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_idx   <= '0;
      rd_idx   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_idx <= wr_idx + 1'b1;
      if (pop)  rd_idx <= rd_idx + 1'b1;
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (pop && !push) fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (MODE != 0 && grant_any) begin
      ptr <= (arb_idx == SW'(N-1)) ? '0 : arb_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      sel_err   <= 1'b0;
    end else begin
      if (grant_any) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_src   <= grant_idx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      sel_err <= drop;
    end
  end

endmodule

// File: tb/tb_merge_n.sv
// Directed bench for merge_n: steered N=4 (a_*), steered N=3 (b_*) and
// round-robin N=4 (c_*) instances sharing one clock and reset.
module tb_merge_n;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0]   a_in_valid, a_in_ready;
  logic [131:0] a_in_data;
  logic         a_sel_valid, a_sel_ready, a_out_valid, a_out_ready, a_sel_err;
  logic [1:0]   a_sel_data, a_out_src;
  logic [32:0]  a_out_data;

  logic [2:0]   b_in_valid, b_in_ready;
  logic [98:0]  b_in_data;
  logic         b_sel_valid, b_sel_ready, b_out_valid, b_out_ready, b_sel_err;
  logic [1:0]   b_sel_data, b_out_src;
  logic [32:0]  b_out_data;

  logic [3:0]   c_in_valid, c_in_ready;
  logic [131:0] c_in_data;
  logic         c_sel_valid, c_sel_ready, c_out_valid, c_out_ready, c_sel_err;
  logic [1:0]   c_sel_data, c_out_src;
  logic [32:0]  c_out_data;

  logic [32:0] a_d [4];
  logic [32:0] b_d [3];
  logic [32:0] c_d [4];
  int drain_src [4];

  merge_n #(.WIDTH(33), .N(4), .SEL_DEPTH(4), .MODE(0)) dut_a (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .sel_valid(a_sel_valid), .sel_ready(a_sel_ready),
    .sel_data(a_sel_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_src(a_out_src), .sel_err(a_sel_err));

  merge_n #(.WIDTH(33), .N(3), .SEL_DEPTH(4), .MODE(0)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .sel_valid(b_sel_valid), .sel_ready(b_sel_ready),
    .sel_data(b_sel_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_src(b_out_src), .sel_err(b_sel_err));

  merge_n #(.WIDTH(33), .N(4), .SEL_DEPTH(4), .MODE(1)) dut_c (
    .clk(clk), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .sel_valid(c_sel_valid), .sel_ready(c_sel_ready),
    .sel_data(c_sel_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .out_src(c_out_src), .sel_err(c_sel_err));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  initial begin
    a_d[0] = 33'h1_0000_00A0; a_d[1] = 33'h0_FFFF_FFA1;
    a_d[2] = 33'h1_2345_67A2; a_d[3] = 33'h0_8000_00A3;
    b_d[0] = 33'h0_0000_0B00; b_d[1] = 33'h1_DEAD_BEB1; b_d[2] = 33'h0_5555_5B02;
    c_d[0] = 33'h1_CCCC_0C00; c_d[1] = 33'h0_0000_0C01;
    c_d[2] = 33'h1_FFFF_FC02; c_d[3] = 33'h0_7777_7C03;
    drain_src[0] = 2; drain_src[1] = 3; drain_src[2] = 0; drain_src[3] = 1;
    a_in_data = {a_d[3], a_d[2], a_d[1], a_d[0]};
    b_in_data = {b_d[2], b_d[1], b_d[0]};
    c_in_data = {c_d[3], c_d[2], c_d[1], c_d[0]};
    a_in_valid = '0; a_sel_valid = 0; a_sel_data = '0; a_out_ready = 0;
    b_in_valid = '0; b_sel_valid = 0; b_sel_data = '0; b_out_ready = 0;
    c_in_valid = '0; c_sel_valid = 0; c_sel_data = '0; c_out_ready = 0;

    // Reset values
    neg(); neg();
    reset = 0;
    #1;
    check("rst_a_out_valid", a_out_valid, 0);
    check("rst_a_out_data", a_out_data, 0);
    check("rst_a_out_src", a_out_src, 0);
    check("rst_a_sel_err", a_sel_err, 0);
    check("rst_a_in_ready", a_in_ready, 0);
    check("rst_a_sel_ready", a_sel_ready, 1);
    check("rst_b_sel_ready", b_sel_ready, 1);
    check("rst_c_sel_ready", c_sel_ready, 0);
    check("rst_c_out_valid", c_out_valid, 0);

    // Steered order 2,0,3 with input 0 late
    a_out_ready = 1;
    neg(); a_in_valid = 4'b1100; a_sel_valid = 1; a_sel_data = 2; #1;
    check("s1_empty_in_ready", a_in_ready, 4'b0000);
    neg(); a_sel_data = 0; #1;
    check("s1_in_ready_2", a_in_ready, 4'b0100);
    check("s1_out_valid_0", a_out_valid, 0);
    neg(); a_in_valid = 4'b1000; a_sel_data = 3; #1;
    check("s1_out_valid_2", a_out_valid, 1);
    check("s1_out_src_2", a_out_src, 2);
    check("s1_out_data_2", a_out_data, a_d[2]);
    check("s1_in3_waits", a_in_ready, 4'b0000);
    neg(); a_sel_valid = 0; a_in_valid = 4'b1001; #1;
    check("s1_drained", a_out_valid, 0);
    check("s1_in_ready_0", a_in_ready, 4'b0001);
    neg(); a_in_valid = 4'b1000; #1;
    check("s1_out_src_0", a_out_src, 0);
    check("s1_out_data_0", a_out_data, a_d[0]);
    check("s1_in_ready_3", a_in_ready, 4'b1000);
    neg(); a_in_valid = 4'b0000; #1;
    check("s1_out_src_3", a_out_src, 3);
    check("s1_out_data_3", a_out_data, a_d[3]);
    check("s1_in_ready_idle", a_in_ready, 4'b0000);
    neg(); #1;
    check("s1_end_valid", a_out_valid, 0);

    // Fill select FIFO under backpressure, then drain in order
    a_out_ready = 0;
    neg(); a_sel_valid = 1; a_sel_data = 1; #1;
    check("s2_sel_ready_start", a_sel_ready, 1);
    neg(); a_sel_data = 2;
    neg(); a_sel_data = 3;
    neg(); a_sel_data = 0;
    neg(); a_sel_data = 1; #1;
    check("s2_full", a_sel_ready, 0);
    neg(); a_in_valid = 4'b1111; #1;
    check("s2_in_ready_1", a_in_ready, 4'b0010);
    check("s2_still_full", a_sel_ready, 0);
    neg(); #1;
    check("s2_held_valid", a_out_valid, 1);
    check("s2_held_src", a_out_src, 1);
    check("s2_held_data", a_out_data, a_d[1]);
    check("s2_space_after_pop", a_sel_ready, 1);
    check("s2_blocked", a_in_ready, 4'b0000);
    neg(); a_sel_valid = 0; #1;
    check("s2_full_again", a_sel_ready, 0);
    check("s2_stable_data", a_out_data, a_d[1]);
    neg(); a_out_ready = 1; #1;
    check("s2_stable_data2", a_out_data, a_d[1]);
    check("s2_in_ready_2", a_in_ready, 4'b0100);
    for (int k = 0; k < 4; k++) begin
      neg(); if (k == 3) a_in_valid = 4'b0000; #1;
      check("s2_drain_valid", a_out_valid, 1);
      check("s2_drain_src", a_out_src, 64'(drain_src[k]));
      check("s2_drain_data", a_out_data, a_d[drain_src[k]]);
    end
    neg(); #1;
    check("s2_end_valid", a_out_valid, 0);
    check("s2_end_sel_ready", a_sel_ready, 1);

    // Out-of-range select on N=3
    b_out_ready = 1;
    neg(); b_in_valid = 3'b011; b_sel_valid = 1; b_sel_data = 3; #1;
    check("s3_in_ready_empty", b_in_ready, 3'b000);
    neg(); b_sel_data = 1; #1;
    check("s3_no_ready_bad", b_in_ready, 3'b000);
    check("s3_err_before", b_sel_err, 0);
    neg(); b_sel_valid = 0; #1;
    check("s3_err_pulse", b_sel_err, 1);
    check("s3_out_empty", b_out_valid, 0);
    check("s3_in_ready_1", b_in_ready, 3'b010);
    neg(); b_in_valid = 3'b000; #1;
    check("s3_err_clear", b_sel_err, 0);
    check("s3_out_src", b_out_src, 1);
    check("s3_out_data", b_out_data, b_d[1]);
    neg(); #1;
    check("s3_end_valid", b_out_valid, 0);
    check("s3_no_err", b_sel_err, 0);

    // Round-robin with all inputs requesting
    c_out_ready = 1;
    neg(); c_in_valid = 4'b1111; #1;
    check("s4_first_grant", c_in_ready, 4'b0001);
    for (int k = 1; k <= 8; k++) begin
      neg(); #1;
      check("s4_rr_valid", c_out_valid, 1);
      check("s4_rr_src", c_out_src, 64'((k - 1) % 4));
      check("s4_rr_data", c_out_data, c_d[(k - 1) % 4]);
      check("s4_rr_grant", c_in_ready, 64'(4'b0001 << (k % 4)));
    end
    neg(); c_in_valid = 4'b0100; #1;
    check("s4_last_rr_src", c_out_src, 0);
    check("s4_only2_grant", c_in_ready, 4'b0100);
    for (int k = 0; k < 3; k++) begin
      neg(); #1;
      check("s4_only2_src", c_out_src, 2);
      check("s4_only2_data", c_out_data, c_d[2]);
      check("s4_only2_ready", c_in_ready, 4'b0100);
    end

    // Backpressure toggling on the arbitrated instance (ptr now 3)
    neg(); c_in_valid = 4'b0000; #1;
    check("s5_pre_src", c_out_src, 2);
    check("s5_pre_ready", c_in_ready, 4'b0000);
    neg(); c_in_valid = 4'b1111; #1;
    check("s5_empty", c_out_valid, 0);
    check("s5_grant3", c_in_ready, 4'b1000);
    neg(); c_out_ready = 0; #1;
    check("s5_src3", c_out_src, 3);
    check("s5_stall_ready", c_in_ready, 4'b0000);
    neg(); c_out_ready = 1; #1;
    check("s5_src3_stable", c_out_src, 3);
    check("s5_data3_stable", c_out_data, c_d[3]);
    check("s5_grant0", c_in_ready, 4'b0001);
    neg(); c_out_ready = 0; #1;
    check("s5_src0", c_out_src, 0);
    check("s5_data0", c_out_data, c_d[0]);
    check("s5_stall_ready2", c_in_ready, 4'b0000);
    neg(); c_out_ready = 1; #1;
    check("s5_src0_stable", c_out_src, 0);
    check("s5_grant1", c_in_ready, 4'b0010);
    neg(); c_out_ready = 0; #1;
    check("s5_src1", c_out_src, 1);
    check("s5_data1", c_out_data, c_d[1]);
    neg(); c_in_valid = 4'b0000; c_out_ready = 1; #1;
    check("s5_src1_stable", c_out_src, 1);
    check("s5_valid_held", c_out_valid, 1);
    neg(); #1;
    check("s5_end_valid", c_out_valid, 0);

    // Reset with full FIFO and loaded output register
    a_out_ready = 0; a_in_valid = 4'b0001;
    neg(); a_sel_valid = 1; a_sel_data = 0;
    neg(); #1;
    check("s6_in_ready_0", a_in_ready, 4'b0001);
    neg(); neg(); neg();
    neg(); a_sel_valid = 0; #1;
    check("s6_full", a_sel_ready, 0);
    check("s6_loaded", a_out_valid, 1);
    check("s6_loaded_data", a_out_data, a_d[0]);
    #2 reset = 1;
    #1;
    check("s6_rst_valid", a_out_valid, 0);
    check("s6_rst_data", a_out_data, 0);
    check("s6_rst_src", a_out_src, 0);
    check("s6_rst_err", a_sel_err, 0);
    check("s6_rst_in_ready", a_in_ready, 4'b0000);
    neg(); reset = 0; a_in_valid = 4'b0100; a_sel_valid = 1; a_sel_data = 2;
    a_out_ready = 1; #1;
    check("s6_post_sel_ready", a_sel_ready, 1);
    check("s6_post_empty", a_in_ready, 4'b0000);
    neg(); a_sel_valid = 0; #1;
    check("s6_post_grant", a_in_ready, 4'b0100);
    neg(); a_in_valid = 4'b0000; #1;
    check("s6_post_valid", a_out_valid, 1);
    check("s6_post_src", a_out_src, 2);
    check("s6_post_data", a_out_data, a_d[2]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
